// File: rtl/mm_lsu.sv
// mm_lsu: byte-serial memory-stage load/store unit between EX and WB.
// Define MM_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mm_lsu #(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [31:0]       wn,
  input  logic [31:0]       mm_mem_n,
  input  logic [4:0]        mm_mem_e,
  output logic              we_o,
  output logic [REG_AW-1:0] wa_o,
  output logic [31:0]       wn_o,
  output logic              stl,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TLAST =
    WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state, nstate;
  logic [1:0]          cnt;
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         sdat;
  logic [31:0]         rbuf;
  logic [31:0]         ext;
  logic [1:0]          size;
  logic                st, uns, lwe;
  logic [REG_AW-1:0]   lwa;
  logic [WW-1:0]       wcnt;
  logic                mop, last, tmo, mis;

  assign mop  = mm_mem_e[4];
  assign last = (cnt == size);
  assign tmo  = (TIMEOUT > 0) && (wcnt == TLAST);

`ifdef MM_LSU_MISALIGN_TRAP_EN
  assign mis = ((mm_mem_e[3:2] == 2'd1) && wn[0]) ||
               ((mm_mem_e[3:2] == 2'd3) && (wn[1:0] != 2'd0));
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (mop) nstate = mis ? DONE : BUS;
      BUS: begin
        if (mem_ack) begin
          if (last) nstate = DONE;
        end else if (tmo) begin
          nstate = DONE;
        end
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    stl      = 1'b0;
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    mem_a    = '0;
    mem_dout = 8'h00;
    unique case (state)
      IDLE: stl = rst & mop;
      BUS: begin
        stl      = 1'b1;
        mem_req  = 1'b1;
        mem_wr   = st;
        mem_a    = addr + ADDR_W'(cnt);
        mem_dout = sdat[{cnt, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Sign source is the top byte actually transferred
  always_comb begin
    unique case (size)
      2'd0:    ext = {{24{~uns & rbuf[7]}}, rbuf[7:0]};
      2'd1:    ext = {{16{~uns & rbuf[15]}}, rbuf[15:0]};
      default: ext = rbuf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_o <= 1'b0;
      wa_o <= '0;
      wn_o <= '0;
      err  <= 1'b0;
      cnt  <= '0;
      addr <= '0;
      sdat <= '0;
      rbuf <= '0;
      size <= '0;
      st   <= 1'b0;
      uns  <= 1'b0;
      lwe  <= 1'b0;
      lwa  <= '0;
      wcnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          err <= 1'b0;
          if (mop) begin
            addr <= ADDR_W'(wn);
            sdat <= mm_mem_n;
            size <= mm_mem_e[3:2];
            st   <= mm_mem_e[1];
            uns  <= mm_mem_e[0];
            lwa  <= wa;
            lwe  <= we;
            cnt  <= '0;
            wcnt <= '0;
            rbuf <= '0;
            we_o <= 1'b0;
            err  <= mis;
          end else begin
            we_o <= we;
            wa_o <= wa;
            wn_o <= wn;
          end
        end
        BUS: begin
          if (mem_ack) begin
            if (!st) rbuf[{cnt, 3'b000} +: 8] <= mem_din;
            wcnt <= '0;
            if (!last) cnt <= cnt + 2'd1;
          end else if (tmo) begin
            err <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        DONE: begin
          err  <= 1'b0;
          wa_o <= lwa;
          // A fault (err) or a store retires nothing to WB
          if (st || err) begin
            we_o <= 1'b0;
            wn_o <= '0;
          end else begin
            we_o <= lwe;
            wn_o <= ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_lsu.sv
// tb_mm_lsu: randomized self-checking bench for mm_lsu.
// Build with MM_LSU_MISALIGN_TRAP_EN to exercise the misalign trap.
module tb_mm_lsu;

  localparam int RW = 5;

  logic          clk = 0;
  logic          rst = 0;
  logic          we = 0;
  logic [RW-1:0] wa = 0;
  logic [31:0]   wn = 0;
  logic [31:0]   mm_mem_n = 0;
  logic [4:0]    mm_mem_e = 0;
  logic          we_o;
  logic [RW-1:0] wa_o;
  logic [31:0]   wn_o;
  logic          stl, err;
  logic          mem_req, mem_wr;
  logic [31:0]   mem_a;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din = 0;
  logic          mem_ack = 0;

  int checks = 0;
  int failures = 0;

  mm_lsu #(.ADDR_W(32), .REG_AW(RW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wn(wn),
    .mm_mem_n(mm_mem_n), .mm_mem_e(mm_mem_e),
    .we_o(we_o), .wa_o(wa_o), .wn_o(wn_o),
    .stl(stl), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
  } xfer_t;

  logic [7:0]  mem [logic [31:0]];
  xfer_t       log_q [$];
  int          lat = 0;
  logic        noack = 0;
  int          hold_viol = 0;
  int          wc = 0;
  logic        pend = 0;
  logic [31:0] pa;
  logic [7:0]  pd;
  logic        pw;

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  // Memory model: acks after lat idle cycles, checks request holding
  always @(negedge clk) begin
    if (mem_req) begin
      if (pend && (mem_a !== pa || mem_dout !== pd || mem_wr !== pw))
        hold_viol++;
      if (!noack && wc >= lat) begin
        mem_ack = 1;
        mem_din = get_byte(mem_a);
        if (mem_wr) mem[mem_a] = mem_dout;
        log_q.push_back('{mem_wr, mem_a, mem_dout});
        wc = 0;
        pend = 0;
      end else begin
        mem_ack = 0;
        wc++;
        pend = 1;
        pa = mem_a;
        pd = mem_dout;
        pw = mem_wr;
      end
    end else begin
      mem_ack = 0;
      wc = 0;
      pend = 0;
    end
  end

  function automatic logic is_trap(input logic [4:0] e, input logic [31:0] a);
`ifdef MM_LSU_MISALIGN_TRAP_EN
    return (e[3:2] == 2'd1 && a[0]) || (e[3:2] == 2'd3 && a[1:0] != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: assemble N bytes little-endian, then extend
  function automatic void model(input logic [4:0] e, input logic [31:0] a,
                                output logic [31:0] wn_e, output logic we_e,
                                output int n, output logic trap);
    logic [63:0] v;
    n = int'(e[3:2]) + 1;
    trap = is_trap(e, a);
    v = 0;
    if (e[1] || trap) begin
      wn_e = 0;
      we_e = 0;
    end else begin
      for (int i = 0; i < n; i++)
        v |= 64'(get_byte(a + 32'(i))) << (8 * i);
      if (!e[0] && v[8*n-1]) v |= (~64'd0) << (8 * n);
      wn_e = v[31:0];
      we_e = 1;
    end
  endfunction

  function automatic int log_bad(input logic [4:0] e, input logic [31:0] a,
                                 input logic [31:0] d, input int n);
    int bad = 0;
    if (log_q.size() != n) return 1;
    for (int i = 0; i < n; i++) begin
      if (log_q[i].a !== a + 32'(i) || log_q[i].wr !== e[1]) bad++;
      if (e[1] && log_q[i].d !== d[8*i +: 8]) bad++;
    end
    return bad;
  endfunction

  task automatic run_op(input logic [4:0] e, input logic [31:0] a,
                        input logic [31:0] d, input logic [RW-1:0] w,
                        input int l, output int n_stl, output int n_req,
                        output int n_err, output logic wo,
                        output logic [RW-1:0] wao, output logic [31:0] wno,
                        output logic hung);
    lat = l;
    log_q.delete();
    hold_viol = 0;
    n_stl = 0; n_req = 0; n_err = 0; hung = 1;
    wo = 0; wao = 0; wno = 0;
    @(negedge clk);
    we = 1; wa = w; wn = a; mm_mem_n = d; mm_mem_e = e;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (err) n_err++;
      if (mem_req) n_req++;
      if (stl) n_stl++;
      else begin
        @(posedge clk); #1;
        if (err) n_err++;
        wo = we_o; wao = wa_o; wno = wn_o; hung = 0;
        break;
      end
      @(negedge clk);
      if (c == 0) begin
        we = 0; wa = 0; wn = 0; mm_mem_n = 0; mm_mem_e = 0;
      end
    end
    if (hung) begin
      we = 0; mm_mem_e = 0;
    end
  endtask

  task automatic test_reset;
    rst = 0;
    #1;
    checks++;
    if ({we_o, wa_o, wn_o, stl, err, mem_req, mem_wr, mem_a, mem_dout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we_o=%b wn_o=%h req=%b stl=%b want all 0",
               we_o, wn_o, mem_req, stl);
    end
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_passthrough;
    for (int i = 0; i < 8; i++) begin
      logic          w_e;
      logic [RW-1:0] a_e;
      logic [31:0]   n_e;
      w_e = (i == 0) ? 1'b1 : 1'($urandom);
      a_e = (i == 0) ? 5'd7 : RW'($urandom);
      n_e = (i == 0) ? 32'h1234 : $urandom;
      @(negedge clk);
      we = w_e; wa = a_e; wn = n_e;
      mm_mem_e = {1'b0, 4'($urandom)};
      #1;
      checks++;
      if (stl !== 1'b0) begin
        failures++;
        $display("FAIL pass_stl got %b want 0", stl);
      end
      @(posedge clk); #1;
      checks++;
      if (we_o !== w_e || wa_o !== a_e || wn_o !== n_e) begin
        failures++;
        $display("FAIL pass_wb got %b/%0d/%h want %b/%0d/%h",
                 we_o, wa_o, wn_o, w_e, a_e, n_e);
      end
    end
    @(negedge clk);
    we = 0; mm_mem_e = 0;
  endtask

  task automatic test_lw;
    int n_stl, n_req, n_err;
    logic wo, hung;
    logic [RW-1:0] wao;
    logic [31:0] wno;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    run_op(5'b11100, 32'h100, 0, 5'd3, 0, n_stl, n_req, n_err, wo, wao, wno, hung);
    checks++;
    if (hung || wno !== 32'h44332211 || wo !== 1'b1 || wao !== 5'd3) begin
      failures++;
      $display("FAIL lw_data got we=%b wa=%0d wn=%h want 1/3/44332211", wo, wao, wno);
    end
    checks++;
    if (n_stl !== 5 || n_err !== 0) begin
      failures++;
      $display("FAIL lw_stall got stl=%0d err=%0d want 5/0", n_stl, n_err);
    end
    checks++;
    if (log_bad(5'b11100, 32'h100, 0, 4) !== 0) begin
      failures++;
      $display("FAIL lw_addr got %0d transfers want 0x100..0x103", log_q.size());
    end
  endtask

  task automatic test_ext;
    logic [4:0]  ops [4] = '{5'b10100, 5'b10101, 5'b10000, 5'b10001};
    logic [31:0] adr [4] = '{32'h201, 32'h201, 32'h210, 32'h210};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h0000FF80, 32'hFFFFFF9C, 32'h0000009C};
    mem[32'h201] = 8'h80; mem[32'h202] = 8'hFF; mem[32'h210] = 8'h9C;
    for (int i = 0; i < 4; i++) begin
      int n_stl, n_req, n_err;
      logic wo, hung, trap;
      logic [RW-1:0] wao;
      logic [31:0] wno, wexp;
      trap = is_trap(ops[i], adr[i]);
      wexp = trap ? 32'h0 : exp[i];
      run_op(ops[i], adr[i], 0, 5'd9, 0, n_stl, n_req, n_err, wo, wao, wno, hung);
      checks++;
      if (hung || wno !== wexp || wo !== !trap || n_err !== int'(trap)) begin
        failures++;
        $display("FAIL ext_%0d got we=%b wn=%h err=%0d want we=%b wn=%h",
                 i, wo, wno, n_err, !trap, wexp);
      end
    end
  endtask

  task automatic test_sw_wait;
    int n_stl, n_req, n_err;
    logic wo, hung;
    logic [RW-1:0] wao;
    logic [31:0] wno;
    run_op(5'b11110, 32'h300, 32'hDEADBEEF, 5'd4, 2,
           n_stl, n_req, n_err, wo, wao, wno, hung);
    checks++;
    if (log_bad(5'b11110, 32'h300, 32'hDEADBEEF, 4) !== 0 || hold_viol !== 0) begin
      failures++;
      $display("FAIL sw_bytes got n=%0d hold_viol=%0d want EF,BE,AD,DE held",
               log_q.size(), hold_viol);
    end
    checks++;
    if (hung || wo !== 1'b0 || n_stl !== 13 || n_req !== 12) begin
      failures++;
      $display("FAIL sw_timing got we=%b stl=%0d req=%0d want 0/13/12", wo, n_stl, n_req);
    end
    checks++;
    if (mem[32'h303] !== 8'hDE || mem[32'h300] !== 8'hEF) begin
      failures++;
      $display("FAIL sw_mem got %h_%h want DE_EF", mem[32'h303], mem[32'h300]);
    end
  endtask

  task automatic test_timeout;
    int n_stl, n_req, n_err;
    logic wo, hung;
    logic [RW-1:0] wao;
    logic [31:0] wno;
    noack = 1;
    run_op(5'b11100, 32'h400, 0, 5'd5, 0, n_stl, n_req, n_err, wo, wao, wno, hung);
    noack = 0;
    checks++;
    if (hung || n_req !== 4 || n_err !== 1 || n_stl !== 5 || wo !== 1'b0) begin
      failures++;
      $display("FAIL timeout got req=%0d err=%0d stl=%0d we=%b hung=%b want 4/1/5/0/0",
               n_req, n_err, n_stl, wo, hung);
    end
  endtask

  task automatic test_reset_mid_bus;
    noack = 1;
    @(negedge clk);
    we = 1; wa = 5'd6; wn = 32'h500; mm_mem_e = 5'b11100;
    @(negedge clk);
    we = 0; wa = 0; wn = 0; mm_mem_e = 0;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got req=%b want 1", mem_req);
    end
    rst = 0;
    #1;
    checks++;
    if ({we_o, wa_o, wn_o, stl, err, mem_req, mem_wr, mem_a, mem_dout} !== '0) begin
      failures++;
      $display("FAIL rst_mid got req=%b stl=%b a=%h want all 0", mem_req, stl, mem_a);
    end
    @(negedge clk);
    rst = 1;
    noack = 0;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || stl !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got req=%b stl=%b want 0/0", mem_req, stl);
    end
  endtask

  task automatic test_misalign;
    int n_stl, n_req, n_err, n;
    logic wo, hung, trap, we_e;
    logic [RW-1:0] wao;
    logic [31:0] wno, wn_e;
    model(5'b11100, 32'h102, wn_e, we_e, n, trap);
    run_op(5'b11100, 32'h102, 0, 5'd8, 0, n_stl, n_req, n_err, wo, wao, wno, hung);
`ifdef MM_LSU_MISALIGN_TRAP_EN
    checks++;
    if (hung || n_req !== 0 || n_err !== 1 || n_stl !== 1 || wo !== 1'b0) begin
      failures++;
      $display("FAIL misalign_trap got req=%0d err=%0d stl=%0d we=%b want 0/1/1/0",
               n_req, n_err, n_stl, wo);
    end
`else
    checks++;
    if (hung || n_req !== 4 || n_err !== 0 || n_stl !== 5 || wno !== wn_e) begin
      failures++;
      $display("FAIL misalign_lw got req=%0d err=%0d stl=%0d wn=%h want 4/0/5/%h",
               n_req, n_err, n_stl, wno, wn_e);
    end
`endif
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  sz;
      logic [4:0]  e;
      logic [31:0] a, d, wn_e, wno;
      logic [RW-1:0] w, wao;
      logic we_e, trap, wo, hung;
      int n, l, n_stl, n_req, n_err, es, er;
      sz = 2'($urandom_range(0, 2));
      if (sz == 2) sz = 3;
      e = {1'b1, sz, 1'($urandom), 1'($urandom)};
      a = (k % 8 == 7) ? 32'hFFFFFFFE : 32'h1000 + $urandom_range(0, 15);
      d = $urandom;
      w = RW'($urandom);
      l = $urandom_range(0, 2);
      model(e, a, wn_e, we_e, n, trap);
      es = trap ? 1 : n * (l + 1) + 1;
      er = trap ? 0 : n * (l + 1);
      run_op(e, a, d, w, l, n_stl, n_req, n_err, wo, wao, wno, hung);
      checks++;
      if (hung || wo !== we_e || wno !== wn_e || (we_e && wao !== w)) begin
        failures++;
        $display("FAIL rand_wb op=%b a=%h got we=%b wa=%0d wn=%h want %b/%0d/%h",
                 e, a, wo, wao, wno, we_e, w, wn_e);
      end
      checks++;
      if (n_stl !== es || n_req !== er || n_err !== int'(trap) ||
          log_bad(e, a, d, trap ? 0 : n) !== 0 || hold_viol !== 0) begin
        failures++;
        $display("FAIL rand_bus op=%b a=%h got stl=%0d req=%0d err=%0d want %0d/%0d/%0d",
                 e, a, n_stl, n_req, n_err, es, er, int'(trap));
      end
    end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_lw;
    test_ext;
    test_sw_wait;
    test_timeout;
    test_reset_mid_bus;
    test_misalign;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
